// File: rtl/seg_scan_driver.sv
// Six-digit 7-segment scanner: one shared segment bus, one-hot digit selects, per-frame input snapshot.
// Optional SEG_SCAN_ACTIVE_LOW_EN inverts seg and dig_sel for common-anode displays.
module seg_scan_driver #(
    parameter int CLKS_PER_DIGIT = 1000,
    parameter int BLANK_CYCLES   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] upper10,
    input  logic [7:0] upper01,
    input  logic [7:0] lower1000,
    input  logic [7:0] lower0100,
    input  logic [7:0] lower0010,
    input  logic [7:0] lower0001,
    input  logic       col,
    input  logic       point,
    input  logic       AVS,
    input  logic       DAY,
    input  logic       MAX,
    input  logic       TIM,
    output logic [7:0] seg,
    output logic [5:0] dig_sel,
    output logic [5:0] ann,
    output logic       frame_start,
    output logic       busy
);

`ifdef SEG_SCAN_ACTIVE_LOW_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    localparam int CNT_MAX = (CLKS_PER_DIGIT > BLANK_CYCLES) ? CLKS_PER_DIGIT : BLANK_CYCLES;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [7:0] SEG_OFF = {8{POL}};
    localparam logic [5:0] DIG_OFF = {6{POL}};

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
    // Each slot opens with BLANK unless the blank phase is configured away.
    localparam state_t SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    logic [5:0][7:0] seg_bus;
    logic [5:0]      ann_in;
    assign seg_bus = {lower0001, lower0010, lower0100, lower1000, upper01, upper10};
    assign ann_in  = {TIM, MAX, DAY, AVS, point, col};

    state_t          state_reg, state_next;
    logic [2:0]      d_reg, d_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [5:0][7:0] snap_reg, snap_next;
    logic [5:0]      ann_reg, ann_next;
    logic [7:0]      seg_reg, seg_next;
    logic [5:0]      dig_sel_reg, dig_sel_next;
    logic [5:0]      dig_hot;
    logic            fs_reg, busy_reg;
    logic            take_snap;

    always_comb begin
        state_next = state_reg;
        d_next     = d_reg;
        cnt_next   = cnt_reg;
        take_snap  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next = SLOT_START;
                    d_next     = 3'd0;
                    cnt_next   = '0;
                    take_snap  = 1'b1;
                end
            end
            BLANK: begin
                if (cnt_reg == BLANK_LAST) begin
                    state_next = SHOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            SHOW: begin
                // Enable is only looked at here, so a lit digit always completes its slot.
                if (cnt_reg == SHOW_LAST) begin
                    cnt_next = '0;
                    if (!enable) begin
                        state_next = IDLE;
                        d_next     = 3'd0;
                    end else if (d_reg == 3'd5) begin
                        state_next = SLOT_START;
                        d_next     = 3'd0;
                        take_snap  = 1'b1;
                    end else begin
                        state_next = SLOT_START;
                        d_next     = d_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                d_next     = 3'd0;
                cnt_next   = '0;
            end
        endcase
    end

    assign snap_next = take_snap ? seg_bus : snap_reg;
    assign ann_next  = take_snap ? ann_in : ann_reg;

    // Outputs are computed from the state being entered so they can be registered without lag.
    for (genvar gi = 0; gi < 6; gi++) begin : g_dig
        assign dig_hot[gi] = (state_next == SHOW) && (d_next == 3'(gi));
    end

    assign seg_next     = ((state_next == SHOW) ? snap_next[d_next] : 8'h00) ^ SEG_OFF;
    assign dig_sel_next = dig_hot ^ DIG_OFF;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            d_reg       <= 3'd0;
            cnt_reg     <= '0;
            snap_reg    <= '0;
            ann_reg     <= '0;
            seg_reg     <= SEG_OFF;
            dig_sel_reg <= DIG_OFF;
            fs_reg      <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            d_reg       <= d_next;
            cnt_reg     <= cnt_next;
            snap_reg    <= snap_next;
            ann_reg     <= ann_next;
            seg_reg     <= seg_next;
            dig_sel_reg <= dig_sel_next;
            fs_reg      <= take_snap;
            busy_reg    <= (state_next != IDLE);
        end
    end

    assign seg         = seg_reg;
    assign dig_sel     = dig_sel_reg;
    assign ann         = ann_reg;
    assign frame_start = fs_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: two instances (blank=2 and blank=0) against a frame-position reference model.
// Honours SEG_SCAN_ACTIVE_LOW_EN when compiled with it.
module tb_seg_scan_driver;

    localparam int C = 4;

`ifdef SEG_SCAN_ACTIVE_LOW_EN
    localparam bit POL = 1'b1;
`else
    localparam bit POL = 1'b0;
`endif
    localparam logic [7:0] SEG_OFF = {8{POL}};
    localparam logic [5:0] DIG_OFF = {6{POL}};

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] dig_in [6];
    logic [5:0] flags;        // [0]=col [1]=point [2]=AVS [3]=DAY [4]=MAX [5]=TIM

    logic [7:0] seg0, seg1;
    logic [5:0] dig0, dig1, ann0, ann1;
    logic       fs0, fs1, busy0, busy1;

    int checks = 0;
    int errors = 0;
    int frames = 0;

    always #5 clock = ~clock;

    seg_scan_driver #(.CLKS_PER_DIGIT(C), .BLANK_CYCLES(2)) u_dut0 (
        .clock(clock), .reset(reset), .enable(enable),
        .upper10(dig_in[0]), .upper01(dig_in[1]), .lower1000(dig_in[2]),
        .lower0100(dig_in[3]), .lower0010(dig_in[4]), .lower0001(dig_in[5]),
        .col(flags[0]), .point(flags[1]), .AVS(flags[2]), .DAY(flags[3]),
        .MAX(flags[4]), .TIM(flags[5]),
        .seg(seg0), .dig_sel(dig0), .ann(ann0), .frame_start(fs0), .busy(busy0)
    );

    seg_scan_driver #(.CLKS_PER_DIGIT(C), .BLANK_CYCLES(0)) u_dut1 (
        .clock(clock), .reset(reset), .enable(enable),
        .upper10(dig_in[0]), .upper01(dig_in[1]), .lower1000(dig_in[2]),
        .lower0100(dig_in[3]), .lower0010(dig_in[4]), .lower0001(dig_in[5]),
        .col(flags[0]), .point(flags[1]), .AVS(flags[2]), .DAY(flags[3]),
        .MAX(flags[4]), .TIM(flags[5]),
        .seg(seg1), .dig_sel(dig1), .ann(ann1), .frame_start(fs1), .busy(busy1)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: position t within a 6*P-cycle frame, P = blank + show.
    bit         m_active [2];
    int         m_t      [2];
    logic [7:0] m_snap   [2][6];
    logic [5:0] m_ann    [2];
    bit         m_fs     [2];

    function automatic int blank_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int period_of(input int i);
        return C + blank_of(i);
    endfunction

    task automatic take_snapshot(input int i);
        for (int k = 0; k < 6; k++) m_snap[i][k] = dig_in[k];
        m_ann[i] = flags;
        m_fs[i]  = 1'b1;
    endtask

    initial forever begin
        @(posedge clock or negedge reset);
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                m_active[i] = 1'b0;
                m_t[i]      = 0;
                m_ann[i]    = '0;
                m_fs[i]     = 1'b0;
                for (int k = 0; k < 6; k++) m_snap[i][k] = '0;
            end else begin
                m_fs[i] = 1'b0;
                if (!m_active[i]) begin
                    if (enable) begin
                        m_active[i] = 1'b1;
                        m_t[i]      = 0;
                        take_snapshot(i);
                    end
                end else if ((m_t[i] % period_of(i)) == period_of(i) - 1 && !enable) begin
                    m_active[i] = 1'b0;
                end else begin
                    m_t[i] = (m_t[i] + 1) % (6 * period_of(i));
                    if (m_t[i] == 0) take_snapshot(i);
                end
            end
        end
    end

    function automatic logic [7:0] exp_seg(input int i);
        int slot;
        slot = m_t[i] / period_of(i);
        if (m_active[i] && (m_t[i] % period_of(i)) >= blank_of(i)) return m_snap[i][slot] ^ SEG_OFF;
        return SEG_OFF;
    endfunction

    function automatic logic [5:0] exp_dig(input int i);
        int slot;
        slot = m_t[i] / period_of(i);
        if (m_active[i] && (m_t[i] % period_of(i)) >= blank_of(i)) return (6'd1 << slot) ^ DIG_OFF;
        return DIG_OFF;
    endfunction

    // Per-cycle comparison of both instances at the inactive edge.
    initial forever begin
        @(negedge clock);
        check_value("seg0",  seg0,  exp_seg(0));
        check_value("dig0",  dig0,  exp_dig(0));
        check_value("ann0",  ann0,  m_ann[0]);
        check_value("fs0",   fs0,   m_fs[0]);
        check_value("busy0", busy0, m_active[0]);
        check_value("seg1",  seg1,  exp_seg(1));
        check_value("dig1",  dig1,  exp_dig(1));
        check_value("ann1",  ann1,  m_ann[1]);
        check_value("fs1",   fs1,   m_fs[1]);
        check_value("busy1", busy1, m_active[1]);
        if (m_fs[0]) begin
            frames++;
            $display("frame %0d at %0t: digits %h %h %h %h %h %h ann %b", frames, $time,
                     m_snap[0][0], m_snap[0][1], m_snap[0][2], m_snap[0][3], m_snap[0][4],
                     m_snap[0][5], m_ann[0]);
        end
    end

    task automatic wait_pos(input int slot, input int ph);
        int found;
        found = 0;
        for (int n = 0; n < 300 && found == 0; n++) begin
            @(negedge clock);
            if (m_active[0] && m_t[0] / period_of(0) == slot && m_t[0] % period_of(0) == ph)
                found = 1;
        end
        check_value("wait_pos", found, 1);
    endtask

    task automatic async_reset_pulse();
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_value("rst_seg0",  seg0,  SEG_OFF);
        check_value("rst_dig0",  dig0,  DIG_OFF);
        check_value("rst_ann0",  ann0,  6'd0);
        check_value("rst_fs0",   fs0,   1'b0);
        check_value("rst_busy0", busy0, 1'b0);
        check_value("rst_seg1",  seg1,  SEG_OFF);
        check_value("rst_dig1",  dig1,  DIG_OFF);
        check_value("rst_busy1", busy1, 1'b0);
        repeat (2) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 6; k++) dig_in[k] = '0;
        flags = '0;
        repeat (3) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;

        // Basic scan with 0x01..0x06.
        @(negedge clock);
        for (int k = 0; k < 6; k++) dig_in[k] = 8'(k + 1);
        flags  = 6'b101101;
        enable = 1'b1;
        repeat (80) @(negedge clock);

        // Change last digit mid-frame; the model expects it only at the next frame.
        wait_pos(2, 0);
        dig_in[5] = 8'hFF;
        flags     = 6'b010010;
        repeat (80) @(negedge clock);

        // Drop enable in the second SHOW cycle of slot 3, then re-enable.
        wait_pos(3, 3);
        enable = 1'b0;
        repeat (15) @(negedge clock);
        enable = 1'b1;
        repeat (40) @(negedge clock);

        // Asynchronous reset while slot 4 is lit; released with enable high.
        wait_pos(4, 3);
        async_reset_pulse();
        repeat (60) @(negedge clock);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            @(negedge clock);
            if ($urandom_range(3) == 0) dig_in[$urandom_range(5)] = 8'($urandom);
            if ($urandom_range(7) == 0) flags = 6'($urandom);
            if (enable && $urandom_range(59) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(5) == 0) enable = 1'b1;
            if ($urandom_range(399) == 0) async_reset_pulse();
        end

        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
